// File: rtl/imm_ext_stage_if.sv
// rtl/imm_ext_stage_if.sv - upstream/downstream handshake bundle for the immediate-extension stage
interface imm_ext_stage_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic [TAG_W-1:0] out_tag;

  // Driven by the surrounding pipeline (decode side and execute side)
  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag
  );

  // Driven by the extension stage itself
  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag
  );
endinterface

// File: rtl/imm_ext_stage.sv
// rtl/imm_ext_stage.sv - registered immediate extender with 2-entry skid buffer
module imm_ext_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  imm_ext_stage_if.slave    bus
);
  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext_imm;
  logic [OUT_W-1:0] ext_imm;
  logic             accept;
  logic             drain;

  logic             or_valid_q, or_valid_d;
  logic [OUT_W-1:0] or_imm_q, or_imm_d;
  logic [TAG_W-1:0] or_tag_q, or_tag_d;
  logic             sr_valid_q, sr_valid_d;
  logic [OUT_W-1:0] sr_imm_q, sr_imm_d;
  logic [TAG_W-1:0] sr_tag_q, sr_tag_d;
  logic             in_ready_q, in_ready_d;

  // Extend the incoming immediate; branch offset is the sign-extended value times 4
  always_comb begin
    sext_imm = {{EXT_W{bus.in_imm[IN_W-1]}}, bus.in_imm};
    case (bus.in_mode)
      2'd0:    ext_imm = {{EXT_W{1'b0}}, bus.in_imm};
      2'd1:    ext_imm = sext_imm;
      2'd2:    ext_imm = {bus.in_imm, {EXT_W{1'b0}}};
      default: ext_imm = sext_imm << 2;
    endcase
  end

  // Next state of output and skid registers; skid always drains into output first to keep FIFO order
  always_comb begin
    accept     = bus.in_valid && in_ready_q;
    drain      = or_valid_q && bus.out_ready;
    or_valid_d = or_valid_q;
    or_imm_d   = or_imm_q;
    or_tag_d   = or_tag_q;
    sr_valid_d = sr_valid_q;
    sr_imm_d   = sr_imm_q;
    sr_tag_d   = sr_tag_q;

    if (!or_valid_q || drain) begin
      if (sr_valid_q) begin
        or_valid_d = 1'b1;
        or_imm_d   = sr_imm_q;
        or_tag_d   = sr_tag_q;
        sr_valid_d = 1'b0;
        if (accept) begin
          sr_valid_d = 1'b1;
          sr_imm_d   = ext_imm;
          sr_tag_d   = bus.in_tag;
        end
      end else if (accept) begin
        or_valid_d = 1'b1;
        or_imm_d   = ext_imm;
        or_tag_d   = bus.in_tag;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      sr_valid_d = 1'b1;
      sr_imm_d   = ext_imm;
      sr_tag_d   = bus.in_tag;
    end

    if (flush) begin
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end

    // Ready is registered so upstream never sees a combinational path from out_ready
    in_ready_d = !sr_valid_d;
  end

  // State registers; reset clears everything so outputs read zero and ready stays low during reset
  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid_q <= 1'b0;
      or_imm_q   <= '0;
      or_tag_q   <= '0;
      sr_valid_q <= 1'b0;
      sr_imm_q   <= '0;
      sr_tag_q   <= '0;
      in_ready_q <= 1'b0;
    end else begin
      or_valid_q <= or_valid_d;
      or_imm_q   <= or_imm_d;
      or_tag_q   <= or_tag_d;
      sr_valid_q <= sr_valid_d;
      sr_imm_q   <= sr_imm_d;
      sr_tag_q   <= sr_tag_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = or_valid_q;
  assign bus.out_imm   = or_imm_q;
  assign bus.out_tag   = or_tag_q;
endmodule

// File: tb/tb_imm_ext_stage.sv
// tb/tb_imm_ext_stage.sv - directed self-checking bench for imm_ext_stage
module tb_imm_ext_stage;
  logic clk;
  logic rst;
  logic flush_a;
  logic flush_b;
  int   total;
  int   bad;

  imm_ext_stage_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) a_if ();
  imm_ext_stage_if #(.IN_W(12), .OUT_W(32), .TAG_W(5)) b_if ();

  imm_ext_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_a),
    .bus   (a_if)
  );

  imm_ext_stage #(.IN_W(12), .OUT_W(32), .TAG_W(5)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_b),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
    a_if.in_valid = v;
    a_if.in_imm   = imm;
    a_if.in_mode  = mode;
    a_if.in_tag   = tag;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    flush_a = 1'b0;
    flush_b = 1'b0;
    drive_a(1'b0, 16'h0, 2'd0, 5'd0);
    a_if.out_ready = 1'b0;
    b_if.in_valid  = 1'b0;
    b_if.in_imm    = 12'h0;
    b_if.in_mode   = 2'd0;
    b_if.in_tag    = 5'd0;
    b_if.out_ready = 1'b1;

    // reset state
    tick();
    tick();
    chk("rst_out_valid", {31'd0, a_if.out_valid}, 32'd0);
    chk("rst_out_imm", a_if.out_imm, 32'd0);
    chk("rst_out_tag", {27'd0, a_if.out_tag}, 32'd0);
    chk("rst_in_ready", {31'd0, a_if.in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'd0, a_if.in_ready}, 32'd1);

    // mode sweep, back-to-back, one cycle latency
    a_if.out_ready = 1'b1;
    drive_a(1'b1, 16'h8004, 2'd0, 5'd1);
    tick();
    chk("m0_valid", {31'd0, a_if.out_valid}, 32'd1);
    chk("m0_imm", a_if.out_imm, 32'h00008004);
    chk("m0_tag", {27'd0, a_if.out_tag}, 32'd1);
    drive_a(1'b1, 16'h8004, 2'd1, 5'd2);
    tick();
    chk("m1_imm", a_if.out_imm, 32'hFFFF8004);
    chk("m1_tag", {27'd0, a_if.out_tag}, 32'd2);
    drive_a(1'b1, 16'h8004, 2'd2, 5'd3);
    tick();
    chk("m2_imm", a_if.out_imm, 32'h80040000);
    chk("m2_tag", {27'd0, a_if.out_tag}, 32'd3);
    drive_a(1'b1, 16'h8004, 2'd3, 5'd4);
    tick();
    chk("m3_neg_imm", a_if.out_imm, 32'hFFFE0010);
    chk("m3_neg_tag", {27'd0, a_if.out_tag}, 32'd4);
    drive_a(1'b1, 16'h7FFF, 2'd3, 5'd5);
    tick();
    chk("m3_pos_imm", a_if.out_imm, 32'h0001FFFC);
    chk("m3_pos_tag", {27'd0, a_if.out_tag}, 32'd5);
    drive_a(1'b0, 16'h0, 2'd0, 5'd0);
    tick();
    chk("sweep_idle_valid", {31'd0, a_if.out_valid}, 32'd0);

    // streaming 8 entries at full rate
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, 16'(i * 3), 2'd0, 5'(i));
      tick();
      chk("stream_valid", {31'd0, a_if.out_valid}, 32'd1);
      chk("stream_tag", {27'd0, a_if.out_tag}, 32'(i));
      chk("stream_imm", a_if.out_imm, 32'(i * 3));
      chk("stream_ready", {31'd0, a_if.in_ready}, 32'd1);
    end
    drive_a(1'b0, 16'h0, 2'd0, 5'd0);
    tick();
    chk("stream_end_valid", {31'd0, a_if.out_valid}, 32'd0);

    // back-pressure: 1 -> OR, 2 -> SR, 3 held upstream
    a_if.out_ready = 1'b0;
    drive_a(1'b1, 16'h0011, 2'd0, 5'd1);
    tick();
    chk("bp1_tag", {27'd0, a_if.out_tag}, 32'd1);
    chk("bp1_ready", {31'd0, a_if.in_ready}, 32'd1);
    drive_a(1'b1, 16'h0022, 2'd0, 5'd2);
    tick();
    chk("bp2_ready", {31'd0, a_if.in_ready}, 32'd0);
    chk("bp2_tag", {27'd0, a_if.out_tag}, 32'd1);
    drive_a(1'b1, 16'h0033, 2'd0, 5'd3);
    tick();
    chk("bp3_ready", {31'd0, a_if.in_ready}, 32'd0);
    chk("bp3_stable_tag", {27'd0, a_if.out_tag}, 32'd1);
    chk("bp3_stable_imm", a_if.out_imm, 32'h00000011);
    a_if.out_ready = 1'b1;
    tick();
    chk("rel_tag2", {27'd0, a_if.out_tag}, 32'd2);
    chk("rel_imm2", a_if.out_imm, 32'h00000022);
    chk("rel_ready", {31'd0, a_if.in_ready}, 32'd1);
    tick();
    chk("rel_tag3", {27'd0, a_if.out_tag}, 32'd3);
    chk("rel_imm3", a_if.out_imm, 32'h00000033);
    drive_a(1'b0, 16'h0, 2'd0, 5'd0);
    tick();
    chk("rel_empty", {31'd0, a_if.out_valid}, 32'd0);

    // flush with both registers full and a concurrent offer
    a_if.out_ready = 1'b0;
    drive_a(1'b1, 16'h0AAA, 2'd0, 5'd10);
    tick();
    drive_a(1'b1, 16'h0BBB, 2'd0, 5'd11);
    tick();
    chk("fl_full_ready", {31'd0, a_if.in_ready}, 32'd0);
    drive_a(1'b1, 16'h0CCC, 2'd0, 5'd12);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    drive_a(1'b0, 16'h0, 2'd0, 5'd0);
    chk("fl_valid", {31'd0, a_if.out_valid}, 32'd0);
    chk("fl_ready", {31'd0, a_if.in_ready}, 32'd1);
    a_if.out_ready = 1'b1;
    tick();
    chk("fl_after1", {31'd0, a_if.out_valid}, 32'd0);
    tick();
    chk("fl_after2", {31'd0, a_if.out_valid}, 32'd0);

    // reset mid-stream with both registers full
    a_if.out_ready = 1'b0;
    drive_a(1'b1, 16'h1234, 2'd1, 5'd20);
    tick();
    drive_a(1'b1, 16'h5678, 2'd1, 5'd21);
    tick();
    chk("mr_full_ready", {31'd0, a_if.in_ready}, 32'd0);
    drive_a(1'b1, 16'h9ABC, 2'd1, 5'd22);
    rst = 1'b1;
    tick();
    chk("mr_valid", {31'd0, a_if.out_valid}, 32'd0);
    chk("mr_imm", a_if.out_imm, 32'd0);
    chk("mr_tag", {27'd0, a_if.out_tag}, 32'd0);
    chk("mr_ready", {31'd0, a_if.in_ready}, 32'd0);
    tick();
    chk("mr_ready_hold", {31'd0, a_if.in_ready}, 32'd0);
    rst = 1'b0;
    drive_a(1'b0, 16'h0, 2'd0, 5'd0);
    tick();
    chk("mr_ready_up", {31'd0, a_if.in_ready}, 32'd1);
    chk("mr_post_valid", {31'd0, a_if.out_valid}, 32'd0);
    a_if.out_ready = 1'b1;
    tick();
    chk("mr_no_ghost", {31'd0, a_if.out_valid}, 32'd0);

    // narrow-input variant
    b_if.in_valid = 1'b1;
    b_if.in_imm   = 12'hFFF;
    b_if.in_mode  = 2'd1;
    b_if.in_tag   = 5'd7;
    tick();
    chk("b_m1_imm", b_if.out_imm, 32'hFFFFFFFF);
    chk("b_m1_tag", {27'd0, b_if.out_tag}, 32'd7);
    b_if.in_mode  = 2'd2;
    b_if.in_tag   = 5'd8;
    tick();
    chk("b_m2_imm", b_if.out_imm, 32'hFFF00000);
    b_if.in_mode  = 2'd3;
    b_if.in_tag   = 5'd9;
    tick();
    chk("b_m3_imm", b_if.out_imm, 32'hFFFFFFFC);
    chk("b_m3_tag", {27'd0, b_if.out_tag}, 32'd9);
    b_if.in_valid = 1'b0;
    tick();
    chk("b_idle", {31'd0, b_if.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
